// File: rtl/friscv_pkg.sv
// friscv_pkg: shared FRiscV core constants and types.
//   XLEN, XLEN_BYTES, EXCEPTION_ADDRESS : core-wide constants
//   pc_src_t        : PC mux select encoding
//   pc_ctrl_state_t : redirect controller states
//   exc_cause_t     : exception cause codes reported on cause_out
//   DRAIN_CNT_W     : width of the trap-drain down-counter (DRAIN_CYCLES <= 7)
package friscv_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned XLEN_BYTES        = XLEN / 8;
  localparam logic [XLEN-1:0] EXCEPTION_ADDRESS = 32'h0000_0080;

  localparam int unsigned DRAIN_CNT_W = 3;

  typedef enum logic [1:0] {
    PC_REL  = 2'b00,
    PC_SEQ  = 2'b01,
    PC_EXC  = 2'b10,
    PC_ZERO = 2'b11
  } pc_src_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pc_ctrl_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_EXT      = 2'b01,
    CAUSE_MISALIGN = 2'b10
  } exc_cause_t;

endpackage

// File: rtl/pc_ctrl_sat_counter.sv
// sat_counter: WIDTH-bit up-counter that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : increment request for this cycle
//   count      : current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: redirect controller for the pipelined FRiscV program counter.
// Resolves EX branches, exception requests and load-use stalls into a PC
// mux select/offset pair plus per-stage flushes, and runs a short drain
// window after each trap during which new branches/exceptions are ignored.
//   clk, rst_n           : clock, asynchronous active-low reset
//   pc_in, ex_pc_in      : current PC, PC of the instruction in EX
//   br_taken_in          : taken branch/jump resolved in EX
//   br_offset_in         : branch target offset relative to ex_pc_in
//   exc_req_in           : exception request from EX
//   stall_in             : load-use stall
//   pc_src_out           : 00 relative, 01 sequential, 10 exception, 11 zero
//   alt_pc_out           : offset added to the PC when pc_src_out is 00
//   flush_{if,id,ex}_out : pipeline register flushes
//   epc_out, cause_out   : latched exception PC and cause
//   trap_active_out      : high while draining after a trap
//   redirect_cnt_out     : saturating count of redirects
// Configuration: define FRISCV_EXC_EN to enable exceptions (external requests
// and misaligned branch targets). Without it, exc_req_in is ignored and
// misaligned targets are redirected with the low two bits cleared.
module pc_ctrl
  import friscv_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      ex_pc_in,
  input  logic                 br_taken_in,
  input  logic [XLEN-1:0]      br_offset_in,
  input  logic                 exc_req_in,
  input  logic                 stall_in,
  output logic [1:0]           pc_src_out,
  output logic [XLEN-1:0]      alt_pc_out,
  output logic                 flush_if_out,
  output logic                 flush_id_out,
  output logic                 flush_ex_out,
  output logic [XLEN-1:0]      epc_out,
  output logic [1:0]           cause_out,
  output logic                 trap_active_out,
  output logic [CNT_WIDTH-1:0] redirect_cnt_out
);

`ifdef FRISCV_EXC_EN
  localparam bit ExcEn = 1'b1;
`else
  localparam bit ExcEn = 1'b0;
`endif

  pc_ctrl_state_t         state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [XLEN-1:0]        epc_q, epc_d;
  exc_cause_t             cause_q, cause_d;

  pc_src_t         pc_src;
  logic [XLEN-1:0] alt_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] redir_target;
  logic            flush_if, flush_id, flush_ex;
  logic            redirect;
  logic            trap;
  exc_cause_t      trap_cause;

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    pc_src       = PC_SEQ;
    alt_pc       = '0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    redirect     = 1'b0;
    trap         = 1'b0;
    trap_cause   = CAUSE_NONE;
    target       = ex_pc_in + br_offset_in;
    // Without exceptions a misaligned target cannot trap, so it is aligned.
    redir_target = {target[XLEN-1:2], (ExcEn ? target[1:0] : 2'b00)};

    case (state_q)
      RUN: begin
        if (ExcEn && exc_req_in) begin
          trap       = 1'b1;
          trap_cause = CAUSE_EXT;
        end else if (br_taken_in) begin
          if (ExcEn && (target[1:0] != 2'b00)) begin
            trap       = 1'b1;
            trap_cause = CAUSE_MISALIGN;
          end else begin
            // The PC adder only adds an offset, so express the target as a
            // delta from the current PC. A simultaneous stall is overridden.
            pc_src   = PC_REL;
            alt_pc   = redir_target - pc_in;
            flush_if = 1'b1;
            flush_id = 1'b1;
            redirect = 1'b1;
          end
        end else if (stall_in) begin
          pc_src = PC_REL;
        end

        if (trap) begin
          pc_src      = PC_EXC;
          flush_if    = 1'b1;
          flush_id    = 1'b1;
          flush_ex    = 1'b1;
          redirect    = 1'b1;
          epc_d       = ex_pc_in;
          cause_d     = trap_cause;
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
        end
      end

      default: begin
        if (stall_in) begin
          pc_src = PC_REL;
        end
        if (drain_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      epc_q       <= '0;
      cause_q     <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_redirect_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (redirect),
    .count(redirect_cnt_out)
  );

  assign pc_src_out      = pc_src;
  assign alt_pc_out      = alt_pc;
  assign flush_if_out    = flush_if;
  assign flush_id_out    = flush_id;
  assign flush_ex_out    = flush_ex;
  assign epc_out         = ExcEn ? epc_q : '0;
  assign cause_out       = ExcEn ? cause_q : CAUSE_NONE;
  assign trap_active_out = (state_q == DRAIN);

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: self-checking bench for pc_ctrl. The bench owns the PC
// register (fed from the DUT's select/offset) and a behavioural model that
// predicts the PC, outputs and trap window from the redirect rules.
module tb_pc_ctrl;
  import friscv_pkg::*;

  localparam int unsigned TB_DRAIN = 2;
  localparam int unsigned TB_CNT_W = 8;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

`ifdef FRISCV_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [XLEN-1:0]     pc_in, ex_pc_in, br_offset_in;
  logic                br_taken_in, exc_req_in, stall_in;
  logic [1:0]          pc_src_out;
  logic [XLEN-1:0]     alt_pc_out, epc_out;
  logic                flush_if_out, flush_id_out, flush_ex_out;
  logic [1:0]          cause_out;
  logic                trap_active_out;
  logic [TB_CNT_W-1:0] redirect_cnt_out;

  pc_ctrl #(
    .DRAIN_CYCLES(TB_DRAIN),
    .CNT_WIDTH   (TB_CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_in           (pc_in),
    .ex_pc_in        (ex_pc_in),
    .br_taken_in     (br_taken_in),
    .br_offset_in    (br_offset_in),
    .exc_req_in      (exc_req_in),
    .stall_in        (stall_in),
    .pc_src_out      (pc_src_out),
    .alt_pc_out      (alt_pc_out),
    .flush_if_out    (flush_if_out),
    .flush_id_out    (flush_id_out),
    .flush_ex_out    (flush_ex_out),
    .epc_out         (epc_out),
    .cause_out       (cause_out),
    .trap_active_out (trap_active_out),
    .redirect_cnt_out(redirect_cnt_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Environment PC register, driven by the DUT's mux select/offset.
  logic [XLEN-1:0] env_pc;
  // Reference model state.
  logic [XLEN-1:0] m_pc, m_epc;
  logic [1:0]      m_cause;
  int              m_trap_left;
  int              m_cnt;
  // Values sampled before the last edge.
  logic [1:0]      s_src;
  logic [XLEN-1:0] s_alt;
  logic [2:0]      s_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    env_pc      = '0;
    m_pc        = '0;
    m_epc       = '0;
    m_cause     = 2'b00;
    m_trap_left = 0;
    m_cnt       = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_pc"},    64'(env_pc), 64'(m_pc));
    chk({tag, "_epc"},   64'(epc_out), 64'(m_epc));
    chk({tag, "_cause"}, 64'(cause_out), 64'(m_cause));
    chk({tag, "_trap"},  64'(trap_active_out), 64'(m_trap_left > 0));
    chk({tag, "_cnt"},   64'(redirect_cnt_out), 64'(m_cnt));
  endtask

  // One clock cycle: drive, predict, check combinational outputs, clock,
  // advance environment and model, check registered state.
  task automatic step(input string tag, input logic br, input logic [XLEN-1:0] xpc,
                      input logic [XLEN-1:0] off, input logic exc, input logic st);
    logic [1:0]      e_src;
    logic [XLEN-1:0] e_alt, tgt, nxt_pc;
    logic [2:0]      e_fl;
    logic            take_exc, take_br;
    logic [1:0]      e_cause;
    br_taken_in  = br;
    ex_pc_in     = xpc;
    br_offset_in = off;
    exc_req_in   = exc;
    stall_in     = st;
    pc_in        = env_pc;

    e_src = 2'b01; e_alt = '0; e_fl = 3'b000;
    take_exc = 1'b0; take_br = 1'b0; e_cause = 2'b00;
    tgt = xpc + off;
    if (!EXC_EN) tgt = tgt & ~32'h3;
    nxt_pc = m_pc + 32'd4;
    if (m_trap_left == 0 && EXC_EN && exc) begin
      take_exc = 1'b1; e_cause = 2'b01;
    end else if (m_trap_left == 0 && br) begin
      if (tgt[1:0] != 2'b00) begin
        take_exc = 1'b1; e_cause = 2'b10;
      end else begin
        take_br = 1'b1; e_src = 2'b00; e_alt = tgt - m_pc; e_fl = 3'b110; nxt_pc = tgt;
      end
    end else if (st) begin
      e_src = 2'b00; nxt_pc = m_pc;
    end
    if (take_exc) begin
      e_src = 2'b10; e_fl = 3'b111; nxt_pc = EXCEPTION_ADDRESS;
    end

    #2;
    s_src = pc_src_out;
    s_alt = alt_pc_out;
    s_fl  = {flush_if_out, flush_id_out, flush_ex_out};
    chk({tag, "_src"},   64'(s_src), 64'(e_src));
    chk({tag, "_alt"},   64'(s_alt), 64'(e_alt));
    chk({tag, "_flush"}, 64'(s_fl), 64'(e_fl));

    @(posedge clk);
    case (s_src)
      2'b00:   env_pc = env_pc + s_alt;
      2'b01:   env_pc = env_pc + 32'd4;
      2'b10:   env_pc = EXCEPTION_ADDRESS;
      default: env_pc = '0;
    endcase
    m_pc = nxt_pc;
    if (take_exc || take_br) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    if (take_exc) begin
      m_epc = xpc; m_cause = e_cause; m_trap_left = TB_DRAIN;
    end else if (m_trap_left > 0) begin
      m_trap_left--;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    br_taken_in = 1'b0; exc_req_in = 1'b0; stall_in = 1'b0;
    model_reset();
    #1;
    chk({tag, "_trap"},  64'(trap_active_out), 64'(0));
    chk({tag, "_epc"},   64'(epc_out), 64'(0));
    chk({tag, "_cause"}, 64'(cause_out), 64'(0));
    chk({tag, "_cnt"},   64'(redirect_cnt_out), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_in = '0; ex_pc_in = '0; br_offset_in = '0;
    br_taken_in = 1'b0; exc_req_in = 1'b0; stall_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("rst");
    pc_in = env_pc;
    #1;
    chk("rst_idle_src", 64'(pc_src_out), 64'(2'b01));
    chk("rst_idle_alt", 64'(alt_pc_out), 64'(0));

    // Idle: sequential PC 0, 4, ... 20.
    for (int i = 0; i < 5; i++) idle("idle");
    chk("idle_pc20", 64'(env_pc), 64'(20));

    // Relative branch: target 0x58 expressed as delta 0x38 from 0x20.
    env_pc = 32'h20; m_pc = 32'h20;
    step("br", 1'b1, 32'h18, 32'h40, 1'b0, 1'b0);
    chk("br_alt38", 64'(s_alt), 64'(32'h38));
    chk("br_pc58",  64'(env_pc), 64'(32'h58));
    chk("br_cnt1",  64'(redirect_cnt_out), 64'(1));

    // Branch overrides stall; then a plain stall holds the PC.
    step("br_st", 1'b1, 32'h50, 32'h100, 1'b0, 1'b1);
    chk("br_st_fl", 64'(s_fl), 64'(3'b110));
    for (int i = 0; i < 3; i++) step("stall", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("stall_pc", 64'(env_pc), 64'(32'h150));

    // Exception request and the drain window that follows it.
    step("exc", 1'b0, 32'h100, '0, 1'b1, 1'b0);
    if (EXC_EN) begin
      chk("exc_fl",    64'(s_fl), 64'(3'b111));
      chk("exc_epc",   64'(epc_out), 64'(32'h100));
      chk("exc_cause", 64'(cause_out), 64'(2'b01));
    end
    step("drn_br",  1'b1, 32'h200, 32'h40, 1'b0, 1'b0);
    step("drn_exc", 1'b0, 32'h300, '0, 1'b1, 1'b0);
    chk("drn_done", 64'(trap_active_out), 64'(0));
    idle("post_drn");

    // Misaligned branch target 0x42.
    step("mis", 1'b1, 32'h40, 32'h2, 1'b0, 1'b0);
    chk("mis_pc", 64'(env_pc), 64'(EXC_EN ? EXCEPTION_ADDRESS : 32'h40));
    chk("mis_cause", 64'(cause_out), 64'(EXC_EN ? 2'b10 : 2'b00));
    idle("mis_a"); idle("mis_b");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [XLEN-1:0] off;
      off = {$urandom_range(0, 1023), 2'b00} - 32'd2048;
      if ($urandom_range(0, 7) == 0) off = off + 32'($urandom_range(1, 3));
      step("rnd", ($urandom_range(0, 3) == 0), $urandom & 32'h0000_FFFC, off,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    // Counter saturation.
    do_reset("rst2");
    for (int i = 0; i < CNT_MAX + 4; i++) step("sat", 1'b1, 32'h1000, 32'h10, 1'b0, 1'b0);
    chk("sat_max", 64'(redirect_cnt_out), 64'(CNT_MAX));

    // Reset asserted during the drain window.
    step("pre_rst", 1'b0, 32'h444, '0, 1'b1, 1'b0);
    do_reset("rst_drn");
    idle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Redirect controller driving the select and offset inputs of the pipelined FRiscV program counter. It resolves taken branches from EX, exception requests and hazard stalls into a `pc_src` / `alt_pc` pair plus per-stage flush strobes. It also runs a short trap-drain state machine after each exception and keeps an exception PC.

## Interface
Parameters:
- DRAIN_CYCLES, default 2: cycles after a trap redirect during which new branches/exceptions are ignored (1..7).
- CNT_WIDTH, default 16: width of the redirect counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pc_in  in  XLEN  current PC register value
- ex_pc_in  in  XLEN  PC of the instruction in EX
- br_taken_in  in  1  EX resolved a taken branch/jump
- br_offset_in  in  XLEN  target offset relative to ex_pc_in
- exc_req_in  in  1  exception request from EX
- stall_in  in  1  load-use stall from hazard unit
- pc_src_out  out  2  PC mux select: 00 relative, 01 sequential, 10 exception vector, 11 zero
- alt_pc_out  out  XLEN  offset added to PC when select is 00
- flush_if_out, flush_id_out, flush_ex_out  out  1 each  pipeline register flushes
- epc_out  out  XLEN  latched exception PC
- cause_out  out  2  00 none, 01 external request, 10 misaligned target
- trap_active_out  out  1  high while the state is not RUN
- redirect_cnt_out  out  CNT_WIDTH  saturating count of redirects

## Operation
- States: RUN and DRAIN. Both transition on clk.
- RUN priority, highest first:
  - exc_req_in: pc_src=10; all three flushes high; epc<=ex_pc_in; cause<=01; go to DRAIN.
  - br_taken_in:
    - target = ex_pc_in + br_offset_in, modulo 2^XLEN.
    - alt_pc = target - pc_in, modulo 2^XLEN.
    - pc_src=00; flush_if and flush_id high; flush_ex low.
  - stall_in: pc_src=00, alt_pc=0, so the PC holds. No flush.
  - otherwise pc_src=01, alt_pc=0.
- A branch overrides a simultaneous stall, because the stalled ID instruction is flushed.
- DRAIN:
  - Down-counter loaded with DRAIN_CYCLES-1 on entry.
  - br_taken_in and exc_req_in are ignored; stall_in is still honoured.
  - pc_src=01 otherwise.
  - When the counter is 0, return to RUN on the next edge.
- pc_src=11 is never issued. It is reserved for an external reset-vector override.
- redirect_cnt increments on every branch or exception redirect and saturates at all-ones.
- Reset values:
  - state RUN, drain counter 0, epc_out 0, cause_out 00, redirect_cnt_out 0, trap_active_out 0.
  - Combinational outputs with idle inputs: pc_src_out=01, alt_pc_out=0, all flushes 0.

## Timing
- pc_src_out, alt_pc_out and the flush outputs are combinational from the inputs and state. The PC updates at the next edge.
- Branch at cycle N: pc_in equals target at N+1.
- Exception at cycle N: pc_in = EXCEPTION_ADDRESS, epc_out and cause_out are valid, and trap_active_out is high at N+1. trap_active_out stays high for DRAIN_CYCLES cycles (N+1..N+DRAIN_CYCLES) and is low again at N+DRAIN_CYCLES+1.
- epc_out and cause_out hold until the next exception.
- Reset asserted mid-DRAIN: the block returns to RUN immediately and clears epc, cause and the counter.

## Configuration
- FRISCV_EXC_EN defined:
  - exc_req_in is honoured.
  - A branch target with target[1:0]!=0 is not redirected. It is handled as an exception with epc=ex_pc_in and cause=10.
- FRISCV_EXC_EN undefined:
  - exc_req_in is ignored, the DRAIN state is unreachable, and pc_src=10 is never issued.
  - epc_out and cause_out are tied to 0.
  - Misaligned targets are redirected with target[1:0] forced to 00.

## Structure
- friscv_pkg already defines XLEN, XLEN_BYTES and EXCEPTION_ADDRESS.
- Add to friscv_pkg: pc_src_t enum (PC_REL=2'b00, PC_SEQ=2'b01, PC_EXC=2'b10, PC_ZERO=2'b11), pc_ctrl_state_t (RUN, DRAIN) and exc_cause_t (CAUSE_NONE, CAUSE_EXT, CAUSE_MISALIGN).
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rst_n, inc; output count), instantiated for redirect_cnt.
- The drain counter is inline in pc_ctrl.

## Test plan
- Reset, then idle for 5 cycles -> pc_src=01 every cycle, with PC sequence 0, 4, 8, 12, 16, 20.
- pc_in=0x20, ex_pc_in=0x18, br_offset=0x40, br_taken=1 -> alt_pc=0x38, flush_if and flush_id high; next cycle pc_in=0x58 and redirect_cnt=1.
- stall_in and br_taken in the same cycle -> branch redirect and flushes. stall_in alone for 3 cycles -> pc_src=00, alt_pc=0, PC constant.
- FRISCV_EXC_EN, exc_req with ex_pc_in=0x100 -> pc_src=10 and all flushes high. Next cycle: pc_in=EXCEPTION_ADDRESS, epc_out=0x100, cause=01. trap_active high for 2 cycles. A br_taken and an exc_req inside the window are ignored.
- FRISCV_EXC_EN, branch target 0x42 -> exception with cause=10 and no relative redirect. Without the macro -> PC becomes 0x40.
- Force 2^CNT_WIDTH+3 redirects -> counter stays at all-ones. Assert rst_n during DRAIN -> trap_active=0, epc=0, counter=0.
